cic_decim_ctrl: RTL

- Sequencing controller for the two-stage 4x polyphase CIC decimation filter (ADC TEG datapath).
- Generates the filter's half-rate and quarter-rate phase strobes, its reset and its ENABLE.
- Discards filter start-up transients, then hands each decimated output word to the downstream consumer over a valid/ready handshake.
- Sits between the ADC-side control register bank and the CIC filter instance; one instance per filter.

---
 rtl/cic_ctrl_pkg.sv | 28 ++
 rtl/cic_phase_gen.sv | 39 +++
 rtl/cic_decim_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared constants for the CIC decimation sequencing controller:
// state encodings, default widths and the decimation geometry.
package cic_ctrl_pkg;

   // Default filter input width; the decimated output word is 4 bits wider.
   localparam int CIC_BW = 6;
   localparam int OUT_W  = CIC_BW + 4;

   // Phase counter geometry for the two-stage 4x decimator.
   localparam int PH_W  = 2;
   localparam int DECIM = 4;

   // Width of the shared clear/flush counter (both ranges are 1..15).
   localparam int CNT_W = 4;

   // Controller states, kept as plain constants so the STATE port encoding
   // stays fixed for register-bank readback.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   // True for the states in which the filter is enabled and strobed.
   function automatic logic isActive(input logic [1:0] st);
      return (st == ST_FLUSH) || (st == ST_RUN);
   endfunction

endpackage

// File: rtl/cic_phase_gen.sv
// Phase strobe generator for the 4x polyphase CIC filter. A free-running
// 2-bit phase counter produces a half-rate and a quarter-rate strobe, both
// taken straight from flops so the filter sees glitch-free enables.
module cic_phase_gen
   import cic_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic resN_i,
   input  logic clr_i,
   input  logic run_i,
   output logic clk2En_o,
   output logic clk4En_o
);

   logic [PH_W-1:0] ph_q;
   logic            clk2En_q;
   logic            clk4En_q;

   // Phase counter and strobe flops; counter sits at 0 whenever not running.
   always_ff @(posedge clk_i) begin
      if (!resN_i) begin
         ph_q     <= '0;
         clk2En_q <= 1'b0;
         clk4En_q <= 1'b0;
      end else if (clr_i || !run_i) begin
         ph_q     <= '0;
         clk2En_q <= 1'b0;
         clk4En_q <= 1'b0;
      end else begin
         ph_q     <= ph_q + PH_W'(1);
         clk2En_q <= ph_q[0];
         clk4En_q <= (ph_q == PH_W'(DECIM - 1));
      end
   end

   assign clk2En_o = clk2En_q;
   assign clk4En_o = clk4En_q;

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for the two-stage 4x CIC decimator: resets the
// filter, lets start-up transients flush out, then hands every decimated
// word to the consumer over a valid/ready handshake.
module cic_decim_ctrl
   import cic_ctrl_pkg::*;
#(
   parameter int BW        = CIC_BW,
   parameter int CLR_CYC   = 4,
   parameter int FLUSH_CNT = 4
) (
   input  logic                CLK,
   input  logic                RES,
   input  logic                START,
   input  logic                STOP,
   input  logic signed [BW+3:0] FILT_OUT,
   output logic                CLK_2_EN,
   output logic                CLK_4_EN,
   output logic                FILT_RES_N,
   output logic                FILT_ENABLE,
   output logic signed [BW+3:0] DOUT,
   output logic                DOUT_VALID,
   input  logic                DOUT_READY,
   output logic                OVERRUN,
   output logic                BUSY,
   output logic [1:0]          STATE
);

   localparam int OW = BW + 4;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic signed [OW-1:0] dout_q;
   logic                doutValid_q;
   logic                overrun_q;

   logic clk2En, clk4En;
   logic phRun, phClr;
   logic startAccept, stopAbort, capture;

   assign startAccept = (state_q == ST_IDLE) && START && !STOP;
   assign stopAbort   = (state_q != ST_IDLE) && STOP;
   assign capture     = (state_q == ST_RUN) && clk4En;

   // Phase counter runs only while staying in FLUSH/RUN, so it starts from 0
   // on FLUSH entry and its strobes drop the cycle after a STOP.
   assign phRun = isActive(state_q);
   assign phClr = !isActive(state_d);

   cic_phase_gen u_phase (
      .clk_i   (CLK),
      .resN_i  (RES),
      .clr_i   (phClr),
      .run_i   (phRun),
      .clk2En_o(clk2En),
      .clk4En_o(clk4En)
   );

   // Next-state logic; one counter times CLEAR, then counts flush strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (startAccept) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (STOP) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(CLR_CYC - 1)) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (STOP) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (clk4En) begin
               if (cnt_q == CNT_W'(FLUSH_CNT - 1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_RUN: begin
            if (STOP) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge CLK) begin
      if (!RES) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output handshake: capture on quarter-rate strobes in RUN, drop and flag
   // overrun when the previous word is still unconsumed.
   always_ff @(posedge CLK) begin
      if (!RES) begin
         dout_q      <= '0;
         doutValid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (startAccept) begin
            overrun_q <= 1'b0;
         end
         if (stopAbort) begin
            doutValid_q <= 1'b0;
         end else if (capture) begin
            if (!doutValid_q || DOUT_READY) begin
               dout_q      <= FILT_OUT;
               doutValid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (DOUT_READY) begin
            doutValid_q <= 1'b0;
         end
      end
   end

   assign CLK_2_EN    = clk2En;
   assign CLK_4_EN    = clk4En;
   assign FILT_RES_N  = isActive(state_q);
   assign FILT_ENABLE = isActive(state_q);
   assign DOUT        = dout_q;
   assign DOUT_VALID  = doutValid_q;
   assign OVERRUN     = overrun_q;
   assign BUSY        = (state_q != ST_IDLE);
   assign STATE       = state_q;

endmodule
